execute_stage_md: RTL and testbench

Parametrised successor to the current execute stage. Retains operand forwarding, the ALU and the E→M pipeline register, and adds:
- full RV32M arithmetic: single-cycle multiply and a multi-cycle iterative divide/remainder unit;
- a BusyE stall request to the hazard unit;
- FlushE bubble insertion;
- a synchronous reset and a valid bit on the M register.

Sits between decode/register-read and the memory stage.

---
 rtl/execute_stage_md_pkg.sv | 49 ++++
 rtl/execute_stage_md_div_unit.sv | 99 +++++++++
 rtl/execute_stage_md.sv | 146 ++++++++++++++
 tb/tb_execute_stage_md.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_stage_md_pkg.sv
// Shared types for the execute stage: ALU opcodes, forward selects, divider FSM states.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package exec_md_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_PASSB  = 5'd10,
    OP_MUL    = 5'd11,
    OP_MULH   = 5'd12,
    OP_MULHSU = 5'd13,
    OP_MULHU  = 5'd14,
    OP_DIV    = 5'd15,
    OP_DIVU   = 5'd16,
    OP_REM    = 5'd17,
    OP_REMU   = 5'd18
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RD     = 2'b00,
    FWD_W      = 2'b01,
    FWD_M      = 2'b10,
    FWD_RD_ALT = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic is_div_op(input alu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_div(input alu_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/execute_stage_md_div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU with sign and special-case fix-up.
// Latency: busy for XLEN+1 cycles (launch + XLEN steps), result valid in the following DONE cycle.
// Backpressure: hold keeps the result in DONE; flush aborts from any state.
module div_unit
  import exec_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic            hold,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  quo_q, rem_q, dvsr_q, a_orig_q;
  logic             rem_op_q, neg_q_q, neg_r_q, by_zero_q, ovf_q;
  logic             launch, sgn, a_neg, b_neg;
  logic [XLEN:0]    r_shift, r_diff;
  logic [XLEN-1:0]  q_fix, r_fix;

  // Launch only from IDLE so a held instruction in DONE cannot restart itself.
  assign launch  = start & ~flush & (state == DIV_IDLE);
  assign busy    = launch | (state == DIV_RUN);
  assign done    = (state == DIV_DONE);
  assign sgn     = is_signed_div(op);
  assign a_neg   = sgn & a[XLEN-1];
  assign b_neg   = sgn & b[XLEN-1];
  // Partial remainder shifted left by one, pulling in the next dividend bit.
  assign r_shift = {rem_q, quo_q[XLEN-1]};
  assign r_diff  = r_shift - {1'b0, dvsr_q};

  // FSM, counter and one restoring step per RUN cycle; operands latched at launch.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (launch) begin
            state     <= DIV_RUN;
            cnt       <= CNT_W'(XLEN - 1);
            quo_q     <= a_neg ? -a : a;
            rem_q     <= '0;
            dvsr_q    <= b_neg ? -b : b;
            a_orig_q  <= a;
            rem_op_q  <= (op == OP_REM) || (op == OP_REMU);
            neg_q_q   <= sgn & (a[XLEN-1] ^ b[XLEN-1]);
            neg_r_q   <= a_neg;
            by_zero_q <= (b == '0);
            ovf_q     <= sgn & (a == MIN_VAL) & (b == '1);
          end
        end
        DIV_RUN: begin
          if (!r_diff[XLEN]) begin
            rem_q <= r_diff[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_q <= r_shift[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], 1'b0};
          end
          if (cnt == '0) state <= DIV_DONE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        DIV_DONE: begin
          if (!hold) state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

  // Restore signs, then override with the architected divide-by-zero and overflow results.
  always_comb begin
    q_fix = neg_q_q ? -quo_q : quo_q;
    r_fix = neg_r_q ? -rem_q : rem_q;
    if (by_zero_q) begin
      q_fix = '1;
      r_fix = a_orig_q;
    end else if (ovf_q) begin
      q_fix = MIN_VAL;
      r_fix = '0;
    end
    result = rem_op_q ? r_fix : q_fix;
  end

endmodule

// File: rtl/execute_stage_md.sv
// Execute stage: operand forwarding, ALU with RV32M multiply, iterative divider, E->M register.
// Latency: single-cycle ops reach M in one edge; divides hold E for XLEN+1 cycles then reach M.
// Backpressure: Stall holds M (divider keeps counting); BusyE asks the hazard unit to hold F/D/E.
module execute_stage_md
  import exec_md_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Stall,
  input  logic            FlushE,
  input  logic            ValidE,
  input  logic            RegWriteE,
  input  logic [1:0]      ResultSrcE,
  input  logic            MemWriteE,
  input  logic [4:0]      ALUCtrlE,
  input  logic            ALUSrcE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [4:0]      RdE,
  input  logic [XLEN-1:0] ExtImmE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            BusyE,
  output logic            ValidM,
  output logic            RegWriteM,
  output logic [1:0]      ResultSrcM,
  output logic            MemWriteM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [4:0]      RdM
);

  alu_op_e         op;
  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result_e, div_result;
  logic            is_div, div_done;

  // One multiplier serves all MUL variants; operand sign extension is chosen per op.
  function automatic logic [XLEN-1:0] alu_f(input alu_op_e f_op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [SHAMT_W-1:0] shamt;
    logic               a_sx, b_sx;
    logic [2*XLEN-1:0]  prod;
    shamt = b[SHAMT_W-1:0];
    a_sx  = ((f_op == OP_MULH) || (f_op == OP_MULHSU)) & a[XLEN-1];
    b_sx  = (f_op == OP_MULH) & b[XLEN-1];
    prod  = {{XLEN{a_sx}}, a} * {{XLEN{b_sx}}, b};
    case (f_op)
      OP_ADD:    alu_f = a + b;
      OP_SUB:    alu_f = a - b;
      OP_AND:    alu_f = a & b;
      OP_OR:     alu_f = a | b;
      OP_XOR:    alu_f = a ^ b;
      OP_SLL:    alu_f = a << shamt;
      OP_SRL:    alu_f = a >> shamt;
      OP_SRA:    alu_f = $unsigned($signed(a) >>> shamt);
      OP_SLT:    alu_f = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:   alu_f = {{(XLEN-1){1'b0}}, (a < b)};
      OP_PASSB:  alu_f = b;
      OP_MUL:    alu_f = prod[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  alu_f = prod[2*XLEN-1:XLEN];
      default:   alu_f = '0;
    endcase
  endfunction

  assign op     = alu_op_e'(ALUCtrlE);
  assign is_div = is_div_op(op);

  // Operand A forwarding; 11 aliases the register file value.
  always_comb begin
    case (fwd_sel_e'(ForwardAE))
      FWD_W:   src_a = ResultW;
      FWD_M:   src_a = ALUResultM;
      default: src_a = RD1E;
    endcase
  end

  // Operand B forwarding; store data always takes this value, never the immediate.
  always_comb begin
    case (fwd_sel_e'(ForwardBE))
      FWD_W:   fwd_b = ResultW;
      FWD_M:   fwd_b = ALUResultM;
      default: fwd_b = RD2E;
    endcase
  end

  assign src_b = ALUSrcE ? ExtImmE : fwd_b;

  div_unit #(.XLEN(XLEN)) u_div (
    .clk    (clk),
    .rst    (rst),
    .start  (ValidE & is_div),
    .flush  (FlushE),
    .hold   (Stall),
    .op     (op),
    .a      (src_a),
    .b      (fwd_b),
    .busy   (BusyE),
    .done   (div_done),
    .result (div_result)
  );

  // Divide result only appears once the divider reports DONE; otherwise E is bubbled anyway.
  always_comb begin
    if (is_div) alu_result_e = div_done ? div_result : '0;
    else        alu_result_e = alu_f(op, src_a, src_b);
  end

  // E->M register: reset, then stall hold, then bubble, then load.
  always_ff @(posedge clk) begin
    if (rst) begin
      ValidM     <= 1'b0;
      RegWriteM  <= 1'b0;
      ResultSrcM <= '0;
      MemWriteM  <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      RdM        <= '0;
    end else if (!Stall) begin
      if (FlushE || BusyE || !ValidE) begin
        ValidM     <= 1'b0;
        RegWriteM  <= 1'b0;
        ResultSrcM <= '0;
        MemWriteM  <= 1'b0;
        ALUResultM <= '0;
        WriteDataM <= '0;
        RdM        <= '0;
      end else begin
        ValidM     <= 1'b1;
        RegWriteM  <= RegWriteE;
        ResultSrcM <= ResultSrcE;
        MemWriteM  <= MemWriteE;
        ALUResultM <= alu_result_e;
        WriteDataM <= fwd_b;
        RdM        <= RdE;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage_md.sv
// Self-checking bench for execute_stage_md: vector table, hand sequences, random ops vs model.
// Latency: n/a.
// Backpressure: Stall/FlushE exercised in dedicated sequences.
module tb_execute_stage_md;
  import exec_md_pkg::*;

  logic        clk, rst, Stall, FlushE, ValidE, RegWriteE, MemWriteE, ALUSrcE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [4:0]  ALUCtrlE, RdE;
  logic [31:0] RD1E, RD2E, ExtImmE, ResultW;
  logic        BusyE, ValidM, RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [4:0]  RdM;

  int n_checks = 0;
  int n_fail   = 0;

  execute_stage_md #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .FlushE(FlushE), .ValidE(ValidE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .ALUCtrlE(ALUCtrlE), .ALUSrcE(ALUSrcE), .RD1E(RD1E), .RD2E(RD2E), .RdE(RdE),
    .ExtImmE(ExtImmE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .BusyE(BusyE), .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .MemWriteM(MemWriteM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour from the instruction-set rules using plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    case (op)
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_AND:    return a & b;
      OP_OR:     return a | b;
      OP_XOR:    return a ^ b;
      OP_SLL:    return a << b[4:0];
      OP_SRL:    return a >> b[4:0];
      OP_SRA:    return sa >>> b[4:0];
      OP_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU:   return (a < b) ? 32'd1 : 32'd0;
      OP_PASSB:  return b;
      OP_MUL:    begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      OP_MULH:   begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      OP_MULHSU: begin p = longint'(sa) * longint'({32'd0, b}); return p[63:32]; end
      OP_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      OP_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU:   return (b == 32'd0) ? a : a % b;
      default:   return 32'd0;
    endcase
  endfunction

  // Presents one instruction, waits out any busy period, and lets M load it.
  task automatic exec(input logic [4:0] op, input logic [31:0] rd1, input logic [31:0] rd2,
                      input logic [1:0] fwa, input logic [1:0] fwb, input logic [31:0] resw,
                      input logic alusrc, input logic [31:0] imm, input logic [4:0] rd,
                      output int busy_cnt);
    int   guard;
    logic vm_bad;
    ValidE = 1'b1; RegWriteE = 1'b1; MemWriteE = 1'b0; ResultSrcE = 2'b01;
    ALUCtrlE = op; RD1E = rd1; RD2E = rd2; ForwardAE = fwa; ForwardBE = fwb;
    ResultW = resw; ALUSrcE = alusrc; ExtImmE = imm; RdE = rd;
    #1;
    busy_cnt = 0;
    guard    = 0;
    vm_bad   = 1'b0;
    while (BusyE && guard < 200) begin
      busy_cnt++;
      if (busy_cnt > 1 && ValidM !== 1'b0) vm_bad = 1'b1;
      step();
      guard++;
    end
    if (guard >= 200) check("busy_timeout", 32'(guard), 32'd0);
    if (busy_cnt > 1) check("validm_during_busy", {31'd0, vm_bad}, 32'd0);
    step();
    ValidE = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] rd1, rd2;
    logic [1:0]  fwa, fwb;
    logic [31:0] resw;
    logic        alusrc;
    logic [31:0] imm;
    logic [31:0] exp_res, exp_wd;
    int          exp_busy;
  } vec_t;

  vec_t tbl[19];

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          bc, guard;
    logic        held_bad;
    logic [4:0]  rop;
    logic [31:0] ra, rb, rimm, beff;
    logic        rsrc;
    int          k;

    tbl[0]  = '{OP_ADD,    32'd100,         32'd77,          2'b01, 2'b00, 32'd5,     1'b1, 32'd3,    32'd8,           32'd77,          0};
    tbl[1]  = '{OP_SUB,    32'd9,           32'd0,           2'b10, 2'b00, 32'd0,     1'b1, 32'd3,    32'd5,           32'd0,           0};
    tbl[2]  = '{OP_DIVU,   32'd100,         32'd7,           2'b00, 2'b00, 32'd0,     1'b0, 32'd0,    32'd14,          32'd7,           33};
    tbl[3]  = '{OP_REMU,   32'd100,         32'd7,           2'b00, 2'b00, 32'd0,     1'b0, 32'd0,    32'd2,           32'd7,           33};
    tbl[4]  = '{OP_DIV,    32'd7,           32'd0,           2'b00, 2'b00, 32'd0,     1'b0, 32'd0,    32'hFFFF_FFFF,   32'd0,           33};
    tbl[5]  = '{OP_REM,    32'd7,           32'd0,           2'b00, 2'b00, 32'd0,     1'b0, 32'd0,    32'd7,           32'd0,           33};
    tbl[6]  = '{OP_DIV,    32'h8000_0000,   32'hFFFF_FFFF,   2'b00, 2'b00, 32'd0,     1'b0, 32'd0,    32'h8000_0000,   32'hFFFF_FFFF,   33};
    tbl[7]  = '{OP_REM,    32'h8000_0000,   32'hFFFF_FFFF,   2'b00, 2'b00, 32'd0,     1'b0, 32'd0,    32'd0,           32'hFFFF_FFFF,   33};
    tbl[8]  = '{OP_DIV,    32'hFFFF_FFF9,   32'd2,           2'b00, 2'b00, 32'd0,     1'b0, 32'd0,    32'hFFFF_FFFD,   32'd2,           33};
    tbl[9]  = '{OP_REM,    32'hFFFF_FFF9,   32'd2,           2'b00, 2'b00, 32'd0,     1'b0, 32'd0,    32'hFFFF_FFFF,   32'd2,           33};
    tbl[10] = '{OP_SRA,    32'h8000_0000,   32'd5,           2'b00, 2'b00, 32'd0,     1'b1, 32'h24,   32'hF800_0000,   32'd5,           0};
    tbl[11] = '{OP_MULHU,  32'hFFFF_FFFF,   32'hFFFF_FFFF,   2'b00, 2'b00, 32'd0,     1'b0, 32'd0,    32'hFFFF_FFFE,   32'hFFFF_FFFF,   0};
    tbl[12] = '{OP_MULH,   32'hFFFF_FFFF,   32'hFFFF_FFFF,   2'b00, 2'b00, 32'd0,     1'b0, 32'd0,    32'd0,           32'hFFFF_FFFF,   0};
    tbl[13] = '{OP_MULHSU, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   2'b00, 2'b00, 32'd0,     1'b0, 32'd0,    32'hFFFF_FFFF,   32'hFFFF_FFFF,   0};
    tbl[14] = '{OP_SLT,    32'hFFFF_FFFF,   32'd1,           2'b00, 2'b00, 32'd0,     1'b0, 32'd0,    32'd1,           32'd1,           0};
    tbl[15] = '{OP_SLTU,   32'hFFFF_FFFF,   32'd1,           2'b00, 2'b00, 32'd0,     1'b0, 32'd0,    32'd0,           32'd1,           0};
    tbl[16] = '{OP_PASSB,  32'd0,           32'hAAAA,        2'b00, 2'b01, 32'h1234,  1'b0, 32'd0,    32'h1234,        32'h1234,        0};
    tbl[17] = '{5'd31,     32'd1,           32'd2,           2'b00, 2'b00, 32'd0,     1'b0, 32'd0,    32'd0,           32'd2,           0};
    tbl[18] = '{OP_MUL,    32'd12345,       32'd1000,        2'b00, 2'b00, 32'd0,     1'b0, 32'd0,    32'd12345000,    32'd1000,        0};

    rst = 1'b1; Stall = 1'b0; FlushE = 1'b0; ValidE = 1'b0; RegWriteE = 1'b0;
    MemWriteE = 1'b0; ALUSrcE = 1'b0; ResultSrcE = 2'b00; ForwardAE = 2'b00;
    ForwardBE = 2'b00; ALUCtrlE = 5'd0; RdE = 5'd0; RD1E = '0; RD2E = '0;
    ExtImmE = '0; ResultW = '0;
    step(); step();
    rst = 1'b0;
    #1;
    check("reset_validm", {31'd0, ValidM}, 32'd0);
    check("reset_result", ALUResultM, 32'd0);
    check("reset_busy", {31'd0, BusyE}, 32'd0);
    check("reset_wdata", WriteDataM, 32'd0);

    // Vector table
    for (int i = 0; i < 19; i++) begin
      exec(tbl[i].op, tbl[i].rd1, tbl[i].rd2, tbl[i].fwa, tbl[i].fwb, tbl[i].resw,
           tbl[i].alusrc, tbl[i].imm, 5'(i + 1), bc);
      check($sformatf("tbl%0d_result", i), ALUResultM, tbl[i].exp_res);
      check($sformatf("tbl%0d_wdata", i), WriteDataM, tbl[i].exp_wd);
      check($sformatf("tbl%0d_busy", i), 32'(bc), 32'(tbl[i].exp_busy));
      check($sformatf("tbl%0d_validm", i), {31'd0, ValidM}, 32'd1);
      check($sformatf("tbl%0d_rdm", i), {27'd0, RdM}, 32'(i + 1));
    end

    // Flush in the tenth RUN cycle aborts the divide
    ValidE = 1'b1; ALUCtrlE = OP_DIVU; RD1E = 32'd100; RD2E = 32'd7;
    ForwardAE = 2'b00; ForwardBE = 2'b00; ALUSrcE = 1'b0;
    step();
    for (int i = 0; i < 9; i++) step();
    check("flush_busy_before", {31'd0, BusyE}, 32'd1);
    FlushE = 1'b1;
    step();
    FlushE = 1'b0; ValidE = 1'b0;
    #1;
    check("flush_busy_after", {31'd0, BusyE}, 32'd0);
    check("flush_validm", {31'd0, ValidM}, 32'd0);
    check("flush_regwritem", {31'd0, RegWriteM}, 32'd0);
    exec(OP_ADD, 32'd2, 32'd3, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 5'd3, bc);
    check("post_flush_add", ALUResultM, 32'd5);
    check("post_flush_validm", {31'd0, ValidM}, 32'd1);

    // Stall over the whole divide and three DONE cycles
    exec(OP_ADD, 32'd1, 32'd1, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 5'd4, bc);
    check("stall_pre_add", ALUResultM, 32'd2);
    ValidE = 1'b1; ALUCtrlE = OP_DIVU; RD1E = 32'd100; RD2E = 32'd7; Stall = 1'b1;
    #1;
    bc = 0; guard = 0; held_bad = 1'b0;
    while (BusyE && guard < 200) begin
      bc++;
      if (ALUResultM !== 32'd2) held_bad = 1'b1;
      step();
      guard++;
    end
    check("stall_run_busy_cycles", 32'(bc), 32'd33);
    check("stall_run_m_held", {31'd0, held_bad}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_done%0d_result", i), ALUResultM, 32'd2);
      check($sformatf("stall_done%0d_validm", i), {31'd0, ValidM}, 32'd1);
      check($sformatf("stall_done%0d_busy", i), {31'd0, BusyE}, 32'd0);
    end
    Stall = 1'b0;
    step();
    ValidE = 1'b0;
    check("stall_release_result", ALUResultM, 32'd14);
    check("stall_release_validm", {31'd0, ValidM}, 32'd1);

    // Reset in the middle of a divide
    exec(OP_ADD, 32'd4, 32'd5, 2'b00, 2'b00, 32'd0, 1'b0, 32'd0, 5'd9, bc);
    check("rst_pre_add", ALUResultM, 32'd9);
    ValidE = 1'b1; ALUCtrlE = OP_DIVU; RD1E = 32'd100; RD2E = 32'd7; Stall = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("rst_mid_busy", {31'd0, BusyE}, 32'd1);
    check("rst_mid_m_held", ALUResultM, 32'd9);
    rst = 1'b1; ValidE = 1'b0; Stall = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check("rst_result", ALUResultM, 32'd0);
    check("rst_validm", {31'd0, ValidM}, 32'd0);
    check("rst_regwritem", {31'd0, RegWriteM}, 32'd0);
    check("rst_wdata", WriteDataM, 32'd0);
    check("rst_rdm", {27'd0, RdM}, 32'd0);
    check("rst_busy", {31'd0, BusyE}, 32'd0);

    // Randomized ops against the reference model
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 22);
      if (k < 19) rop = 5'(k);
      else        rop = 5'($urandom_range(19, 31));
      ra   = rnd_val();
      rb   = rnd_val();
      rimm = rnd_val();
      rsrc = 1'($urandom_range(0, 1));
      beff = (is_div_op(alu_op_e'(rop)) || !rsrc) ? rb : rimm;
      exec(rop, ra, rb, 2'b00, 2'b00, 32'd0, rsrc, rimm, 5'd11, bc);
      check($sformatf("rnd%0d_op%0d_result", n, rop), ALUResultM, model(rop, ra, beff));
      check($sformatf("rnd%0d_wdata", n), WriteDataM, rb);
      check($sformatf("rnd%0d_busy", n), 32'(bc),
            is_div_op(alu_op_e'(rop)) ? 32'd33 : 32'd0);
      check($sformatf("rnd%0d_validm", n), {31'd0, ValidM}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
